frame_update_scheduler: RTL
===========================

FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchronizer flops on ce (legal range 2-4).
REQ-002 SHALL have parameter VSYNC_ACTIVE_LOW, default 1, meaning frame boundary is a v_sync 1->0 transition (0: 0->1 transition).
REQ-003 SHALL have parameter HOLDOFF_FRAMES, default 1, meaning frame boundaries skipped after a commit before the next commit (0-15).
REQ-004 SHALL have port VGA_clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ce  input  1  SPI chip enable from MCU, asynchronous; low means transaction in progress.
REQ-007 SHALL have port spi_data  input  8  received SPI byte; stable while ce is high.
REQ-008 SHALL have port v_sync  input  1  VGA vertical sync, synchronous to VGA_clk.
REQ-009 SHALL have port GAME_new_frame_ready  output  1  one-cycle commit strobe to the state manager.
REQ-010 SHALL have port GAME_frame_select  output  4  committed frame select to the game encoder.
REQ-011 SHALL have port pending  output  1  a captured select awaits commit.
REQ-012 SHALL have port drop_count  output  8  captured selects overwritten before commit, saturating.
REQ-013 SHALL have port commit_count  output  16  commits issued, wrapping.

Function
REQ-014 SHALL pass ce through SYNC_STAGES flops, all resetting to 1; capture event = synchronized ce 0->1 transition (one-cycle detect).
REQ-015 SHALL, on capture event in cycle T, load staged <= spi_data[3:0] and set pending = 1 at T+1.
REQ-016 SHALL, on capture while pending already 1 and not consumed that cycle, overwrite staged and increment drop_count, saturating at 255.
REQ-017 SHALL detect frame boundary from v_sync and a registered previous v_sync (reset value = inactive level), one cycle per transition.
REQ-018 SHALL implement FSM states IDLE, WAIT_FRAME, COMMIT, HOLDOFF.
REQ-019 IDLE: pending = 1 -> WAIT_FRAME; frame boundaries ignored.
REQ-020 WAIT_FRAME: frame boundary -> COMMIT; a capture in that same cycle updates staged, counts a drop, and the new value is committed.
REQ-021 COMMIT (exactly one cycle): GAME_new_frame_ready = 1, GAME_frame_select <= staged, pending cleared, commit_count + 1 (wraps 65535 -> 0); next HOLDOFF if HOLDOFF_FRAMES > 0, else IDLE.
REQ-022 A capture in the COMMIT cycle SHALL set pending again for the next commit and SHALL NOT count a drop.
REQ-023 HOLDOFF: 4-bit counter loaded with HOLDOFF_FRAMES on COMMIT, decremented per frame boundary; at 0 -> WAIT_FRAME if pending else IDLE.
REQ-024 The boundary that ends HOLDOFF SHALL NOT also commit; commit requires a later boundary.
REQ-025 GAME_frame_select SHALL change only in COMMIT and hold otherwise.
REQ-026 GAME_new_frame_ready SHALL be 0 in all states except COMMIT; never high two consecutive cycles.
REQ-027 Captures SHALL be accepted in every state; no capture is lost without incrementing drop_count.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, GAME_new_frame_ready 0, GAME_frame_select 0, pending 0, drop_count 0, commit_count 0, staged 0, holdoff counter 0, ce synchronizer 1s, previous v_sync inactive.
REQ-029 Reset mid-transaction (ce low) SHALL discard it; a ce rise after reset release SHALL be captured normally.
REQ-030 Outputs SHALL remain at reset values until the first capture following reset release.

Verification
REQ-031 Defaults; spi_data=0x05, ce low 10 cycles then high; v_sync falls 100 cycles later -> one strobe 1 cycle after boundary detect, GAME_frame_select=5, commit_count=1, pending=0.
REQ-032 Two transactions (0x03 then 0x0A) before any boundary -> drop_count=1, next commit GAME_frame_select=0xA.
REQ-033 HOLDOFF_FRAMES=1; capture 0x2, commit, capture 0x7 immediately -> no commit on next boundary, commit 0x7 on the following boundary.
REQ-034 Capture detect coincident with boundary in WAIT_FRAME (staged 0x1, new 0x9) -> committed value 0x9, drop_count=1.
REQ-035 Assert reset while pending=1 with staged 0xC -> all outputs 0 immediately; subsequent boundaries produce no strobe.
REQ-036 Drive 300 overwriting captures with no boundary -> drop_count holds at 255; 65536 commits -> commit_count wraps to 0.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// Latches an MCU-selected frame index at the end of each SPI transaction and
// hands it to the game encoder on a VGA frame boundary, with optional holdoff.
module frame_update_scheduler #(
  parameter int SYNC_STAGES      = 2,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int HOLDOFF_FRAMES   = 1
) (
  input  logic        VGA_clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [7:0]  spi_data,
  input  logic        v_sync,
  output logic        GAME_new_frame_ready,
  output logic [3:0]  GAME_frame_select,
  output logic        pending,
  output logic [7:0]  drop_count,
  output logic [15:0] commit_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    COMMIT     = 2'd2,
    HOLDOFF    = 2'd3
  } state_t;

  localparam logic       VS_INACTIVE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLDOFF_FRAMES);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ce_prev_q, ce_prev_d;
  logic                   vs_prev_q, vs_prev_d;
  logic [3:0]             staged_q, staged_d;
  logic                   pending_q, pending_d;
  logic [7:0]             drop_q, drop_d;
  logic [15:0]            commit_cnt_q, commit_cnt_d;
  logic [3:0]             hold_q, hold_d;
  logic                   ready_q, ready_d;
  logic [3:0]             sel_q, sel_d;

  logic                   ce_s;
  logic                   capture_s;
  logic                   boundary_s;
  logic                   commit_go_s;
  logic [3:0]             unused_spi_hi_s;

  assign unused_spi_hi_s = spi_data[7:4];

  assign ce_s        = sync_q[SYNC_STAGES-1];
  assign capture_s   = ce_s & ~ce_prev_q;
  assign boundary_s  = VSYNC_ACTIVE_LOW ? (vs_prev_q & ~v_sync) : (~vs_prev_q & v_sync);
  assign commit_go_s = (state_q == WAIT_FRAME) & boundary_s;

  // Next-state and datapath computation for every register
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], ce};
    ce_prev_d    = ce_s;
    vs_prev_d    = v_sync;
    state_d      = state_q;
    hold_d       = hold_q;
    ready_d      = commit_go_s;

    if (capture_s) begin
      staged_d = spi_data[3:0];
    end else begin
      staged_d = staged_q;
    end

    // A capture that lands on the consuming boundary is merged into that commit
    if (commit_go_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q | capture_s;
    end

    if (capture_s && pending_q && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    if (commit_go_s) begin
      commit_cnt_d = commit_cnt_q + 16'd1;
      sel_d        = staged_d;
    end else begin
      commit_cnt_d = commit_cnt_q;
      sel_d        = sel_q;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = WAIT_FRAME;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_FRAME: begin
        if (boundary_s) begin
          state_d = COMMIT;
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      COMMIT: begin
        if (HOLDOFF_FRAMES > 0) begin
          state_d = HOLDOFF;
        end else begin
          state_d = IDLE;
        end
      end
      HOLDOFF: begin
        // Leaving takes a cycle, so the boundary that empties the counter never commits
        if (hold_q == 4'd0) begin
          if (pending_q) begin
            state_d = WAIT_FRAME;
          end else begin
            state_d = IDLE;
          end
        end else if (boundary_s) begin
          hold_d = hold_q - 4'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= {SYNC_STAGES{1'b1}};
      ce_prev_q    <= 1'b1;
      vs_prev_q    <= VS_INACTIVE;
      staged_q     <= 4'd0;
      pending_q    <= 1'b0;
      drop_q       <= 8'd0;
      commit_cnt_q <= 16'd0;
      hold_q       <= 4'd0;
      ready_q      <= 1'b0;
      sel_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      ce_prev_q    <= ce_prev_d;
      vs_prev_q    <= vs_prev_d;
      staged_q     <= staged_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      commit_cnt_q <= commit_cnt_d;
      hold_q       <= hold_d;
      ready_q      <= ready_d;
      sel_q        <= sel_d;
    end
  end

  assign GAME_new_frame_ready = ready_q;
  assign GAME_frame_select    = sel_q;
  assign pending              = pending_q;
  assign drop_count           = drop_q;
  assign commit_count         = commit_cnt_q;

endmodule
